// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU response checker.
//   - FSM state encoding
//   - ALU opcode encodings and the two known Trojan-trigger operand patterns
//   - MISR polynomial and seed
//   - log entry layout {a, b, op, gold_vec, dut_vec}, vec = {result, carry, zero}
package alu_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  // Trigger 0: F + F (ADD). Trigger 1: 0 & F (AND).
  localparam logic [3:0] TRIG0_A  = 4'hF;
  localparam logic [3:0] TRIG0_B  = 4'hF;
  localparam logic [1:0] TRIG0_OP = OP_ADD;
  localparam logic [3:0] TRIG1_A  = 4'h0;
  localparam logic [3:0] TRIG1_B  = 4'hF;
  localparam logic [1:0] TRIG1_OP = OP_AND;

  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // Carry + zero flags appended to each result.
  localparam int FLAG_W = 2;

  function automatic int vec_w(input int dw);
    return dw + FLAG_W;
  endfunction

  function automatic int log_w(input int dw, input int ow);
    return 2*dw + ow + 2*vec_w(dw);
  endfunction

  // Field offsets, LSB first: dut_vec, gold_vec, op, b, a.
  function automatic int log_off_dut();
    return 0;
  endfunction

  function automatic int log_off_gold(input int dw);
    return vec_w(dw);
  endfunction

  function automatic int log_off_op(input int dw);
    return 2*vec_w(dw);
  endfunction

  function automatic int log_off_b(input int dw, input int ow);
    return 2*vec_w(dw) + ow;
  endfunction

  function automatic int log_off_a(input int dw, input int ow);
    return 2*vec_w(dw) + ow + dw;
  endfunction

endpackage

// File: rtl/chk_log_fifo.sv
// First-word-fall-through FIFO for mismatch log entries.
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear to empty
//   push/push_data : write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   pop_data   : head entry, valid whenever empty==0
//   full/empty : occupancy flags
module chk_log_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push would need, so full+pop still accepts.
  assign do_push = push & (~full | do_pop) & ~flush;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_response_checker.sv
// On-chip ALU response analyzer.
// Accepts beats of {operands, golden response, DUT response} while running,
// counts tests / mismatches / trigger patterns, logs mismatches into a FWFT
// FIFO and folds DUT responses into a MISR signature.
//   clk, rst          : clock, asynchronous active-high reset
//   start, stop       : run control pulses
//   in_valid/in_ready : beat handshake (ready only in RUN)
//   in_a, in_b, in_op : operands and opcode
//   gold_*, dut_*     : golden and DUT result/carry/zero
//   log_valid/ready/data : mismatch log head {a,b,op,gold_vec,dut_vec}
//   test_count, mismatch_count, trigger_count : saturating counters
//   signature         : MISR state
//   log_overflow      : sticky, a mismatch was dropped on a full log
//   busy, done        : RUN|DRAIN, DONE
module alu_response_checker
  import alu_chk_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int OP_W      = 2,
  parameter int CNT_W     = 16,
  parameter int LOG_DEPTH = 8,
  parameter int MISR_W    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_W-1:0]                     in_a,
  input  logic [DATA_W-1:0]                     in_b,
  input  logic [OP_W-1:0]                       in_op,
  input  logic [DATA_W-1:0]                     gold_result,
  input  logic                                  gold_carry,
  input  logic                                  gold_zero,
  input  logic [DATA_W-1:0]                     dut_result,
  input  logic                                  dut_carry,
  input  logic                                  dut_zero,
  output logic                                  log_valid,
  input  logic                                  log_ready,
  output logic [2*DATA_W+OP_W+2*(DATA_W+2)-1:0] log_data,
  output logic [CNT_W-1:0]                      test_count,
  output logic [CNT_W-1:0]                      mismatch_count,
  output logic [CNT_W-1:0]                      trigger_count,
  output logic [MISR_W-1:0]                     signature,
  output logic                                  log_overflow,
  output logic                                  busy,
  output logic                                  done
);

  localparam int VEC_W    = vec_w(DATA_W);
  localparam int LOG_W    = log_w(DATA_W, OP_W);
  localparam int OFF_DUT  = log_off_dut();
  localparam int OFF_GOLD = log_off_gold(DATA_W);
  localparam int OFF_OP   = log_off_op(DATA_W);
  localparam int OFF_B    = log_off_b(DATA_W, OP_W);
  localparam int OFF_A    = log_off_a(DATA_W, OP_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // ---------------- control FSM ----------------
  chk_state_e state_q, state_d;
  logic       clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start beats a coincident stop here, since stop is only seen in RUN
        if (start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end
      ST_RUN:   if (stop) state_d = ST_DRAIN;
      // One cycle lets the beat accepted alongside stop retire.
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign in_ready = (state_q == ST_RUN);
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);

  // ---------------- stage 1: capture ----------------
  logic              accept;
  logic              s1_vld;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic [OP_W-1:0]   s1_op;
  logic [VEC_W-1:0]  s1_gold, s1_dut;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_op   <= '0;
      s1_gold <= '0;
      s1_dut  <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_op   <= in_op;
        s1_gold <= {gold_result, gold_carry, gold_zero};
        s1_dut  <= {dut_result, dut_carry, dut_zero};
      end
    end
  end

  // ---------------- stage 2: compare / retire ----------------
  logic              mism, trig;
  logic [LOG_W-1:0]  log_entry;
  logic [MISR_W-1:0] sig_shift, sig_next;

  assign mism = (s1_gold != s1_dut);
  assign trig = ((s1_a == DATA_W'(TRIG0_A)) && (s1_b == DATA_W'(TRIG0_B)) &&
                 (s1_op == OP_W'(TRIG0_OP))) ||
                ((s1_a == DATA_W'(TRIG1_A)) && (s1_b == DATA_W'(TRIG1_B)) &&
                 (s1_op == OP_W'(TRIG1_OP)));

  always_comb begin
    log_entry = '0;
    log_entry[OFF_DUT  +: VEC_W]  = s1_dut;
    log_entry[OFF_GOLD +: VEC_W]  = s1_gold;
    log_entry[OFF_OP   +: OP_W]   = s1_op;
    log_entry[OFF_B    +: DATA_W] = s1_b;
    log_entry[OFF_A    +: DATA_W] = s1_a;
  end

  assign sig_shift = {signature[MISR_W-2:0], 1'b0} ^
                     (signature[MISR_W-1] ? MISR_W'(MISR_POLY) : '0);
  assign sig_next  = sig_shift ^ MISR_W'(s1_dut);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_count     <= '0;
      mismatch_count <= '0;
      trigger_count  <= '0;
      signature      <= '0;
    end else if (clear) begin
      test_count     <= '0;
      mismatch_count <= '0;
      trigger_count  <= '0;
      signature      <= MISR_W'(MISR_SEED);
    end else if (s1_vld) begin
      test_count <= sat_inc(test_count);
      if (mism) mismatch_count <= sat_inc(mismatch_count);
      if (trig) trigger_count  <= sat_inc(trigger_count);
      signature <= sig_next;
    end
  end

  // ---------------- mismatch log ----------------
  logic log_push, log_pop, log_full, log_empty, log_drop;

  assign log_push  = s1_vld & mism;
  assign log_pop   = log_ready & log_valid;
  assign log_valid = ~log_empty;
  assign log_drop  = log_push & log_full & ~log_pop;

  chk_log_fifo #(
    .W     (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (log_push),
    .push_data (log_entry),
    .pop       (log_pop),
    .pop_data  (log_data),
    .full      (log_full),
    .empty     (log_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           log_overflow <= 1'b0;
    else if (clear)    log_overflow <= 1'b0;
    else if (log_drop) log_overflow <= 1'b1;
  end

endmodule
